phase_sampler_bank: RTL and testbench
=====================================

Name: phase_sampler_bank

Overview:
- Parametrised multi-bit phase sampler for the unknown-circuit / timing-analysis family.
- Samples bus `a` with a run-time selectable storage element on output `p`: high-transparent latch, low-transparent latch, posedge flop or negedge flop.
- Provides a fixed negedge-sampled output `q`, a DEPTH-deep negedge history, a stability flag and a saturating change counter.
- Used as the capture front-end for characterising unknown sequential circuits.

Parameters:
- WIDTH, 8: bit width of `a`, `p`, `q` and each history slice.
- DEPTH, 4: number of negedge history slices; minimum 2.
- CNT_W, 8: width of the change counter.

Ports:
- clock  in  1  single design clock; both edges are used.
- resetn  in  1  asynchronous reset, active-low.
- a  in  WIDTH  sampled data bus.
- mode  in  2  selects the element driving `p`: 00 latch transparent while clock=1, 01 latch transparent while clock=0, 10 posedge flop, 11 negedge flop.
- p  out  WIDTH  selected storage-element output.
- q  out  WIDTH  value of `a` captured at the most recent negedge.
- hist  out  WIDTH*DEPTH  negedge history; slice k is bits [k*WIDTH +: WIDTH]. Slice 0 is the newest and equals `q`.
- stable  out  1  history is full and all DEPTH slices are equal.
- edge_cnt  out  CNT_W  count of negedges at which the sample differed from the previous `q`; saturating.

Behaviour:
- Reset:
  - resetn=0 asynchronously clears all four `p` elements, `q`, `hist`, the internal fill counter, `stable` and `edge_cnt` to 0, regardless of clock level or mode.
  - Reset overrides latch transparency: `p`=0 while resetn=0 in every mode.
- Storage elements: all four run continuously and in parallel. `p` is a combinational mux of the four, selected by `mode`.
  - L_HI: follows `a` while clock=1; holds while clock=0.
  - L_LO: follows `a` while clock=0; holds while clock=1.
  - F_POS: captures `a` at posedge clock.
  - F_NEG: captures `a` at negedge clock.
- Mode change:
  - `p` takes the newly selected element's current value in the same delta; no clock edge is needed.
  - No element is cleared or resynchronised on a mode change.
- q: identical to F_NEG. Latency is one negedge; there is no combinational path from `a` to `q`.
- hist:
  - At each negedge, slice k takes slice k-1 for k=1..DEPTH-1, and slice 0 takes `a`.
  - The oldest slice is discarded.
- fill: internal counter, 0 at reset, incremented at each negedge, saturating at DEPTH.
- stable:
  - Registered; updated at each negedge from the post-shift history.
  - Equals 1 iff fill==DEPTH and all slices are equal. Otherwise 0.
  - Timing: after reset with `a` held constant, stable rises at the DEPTH-th negedge.
- edge_cnt:
  - At each negedge, if `a` != `q` (pre-edge value), increment by 1, saturating at 2^CNT_W-1.
  - The first negedge after reset compares `a` against `q`=0.
  - edge_cnt never wraps.
- Reset release:
  - Deassertion takes effect immediately.
  - A negedge coincident with release is not required to sample; the first negedge strictly after release must sample.
  - Latches resume transparency per clock level as soon as resetn=1.
- Reset mid-operation:
  - All state returns to 0.
  - fill restarts from 0, so stable stays 0 for at least DEPTH negedges after release.
- X handling: no X on any output after reset while `a` and `mode` are known.

Test Plan:
1. Reset: resetn=0 with clock=1, mode=00, a=0xFF -> p=0, q=0, hist=0, stable=0, edge_cnt=0 immediately. Release with a=0xFF and clock still 1 -> p=0xFF in the same step.
2. mode=00, clock high, a 0x12 then 0x34 -> p tracks 0x12, then 0x34. Negedge -> q=0x34. Then a=0x56 during the low phase -> p holds 0x34.
3. a=0x5A before posedge, 0xA5 during the high phase, 0x3C during the low phase:
   - mode=10 -> p=0x5A from posedge.
   - mode=11 -> p=0xA5 from negedge.
   - mode=01 -> p tracks 0x3C in the low phase.
4. DEPTH=4, a=0xA5 held after reset -> stable 0 for negedges 1-3 and 1 at negedge 4. a=0xA4 at negedge 5 -> stable=0.
5. CNT_W=2, a alternating 0x01/0x02 on successive negedges starting from q=0 -> edge_cnt 1, 2, 3, 3, 3.
6. mode switched 00->10 while clock=0, with L_HI=0x11 and F_POS=0x22 -> p goes 0x11 to 0x22 with no clock edge. Then resetn=0 pulse -> all outputs 0 and stable stays 0 until 4 negedges after release.

Source files
------------

// File: rtl/phase_sampler_bank_if.sv
// Signal bundle for phase_sampler_bank: sampled bus and mode in, sampler views out.
interface phase_sampler_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0]       a;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       p;
  logic [WIDTH-1:0]       q;
  logic [WIDTH*DEPTH-1:0] hist;
  logic                   stable;
  logic [CNT_W-1:0]       edge_cnt;

  modport master (
    output a, mode,
    input  p, q, hist, stable, edge_cnt
  );

  modport slave (
    input  a, mode,
    output p, q, hist, stable, edge_cnt
  );
endinterface

// File: rtl/phase_sampler_bank.sv
// Multi-element phase sampler: two latches and two flops on `a`, a negedge
// history with stability detection, and a saturating change counter.
module phase_sampler_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic                 clock,
  input logic                 resetn,
  phase_sampler_bank_if.slave bus
);

  localparam int FILL_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    SEL_LHI  = 2'b00,
    SEL_LLO  = 2'b01,
    SEL_FPOS = 2'b10,
    SEL_FNEG = 2'b11
  } sel_e;

  logic [WIDTH-1:0]  r_lhi;
  logic [WIDTH-1:0]  r_llo;
  logic [WIDTH-1:0]  r_fpos;
  logic [WIDTH-1:0]  r_hist [DEPTH];
  logic [FILL_W-1:0] r_fill;
  logic              r_stable;
  logic [CNT_W-1:0]  r_cnt;

  logic [WIDTH-1:0]  w_hist_nxt [DEPTH];
  logic [FILL_W-1:0] w_fill_nxt;
  logic              w_all_eq;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0]  w_p;
  sel_e              w_sel;

  assign w_sel = sel_e'(bus.mode);

  always_latch begin
    if (!resetn)
      r_lhi <= '0;
    else if (clock)
      r_lhi <= bus.a;
  end

  always_latch begin
    if (!resetn)
      r_llo <= '0;
    else if (!clock)
      r_llo <= bus.a;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_fpos <= '0;
    else
      r_fpos <= bus.a;
  end

  // Slice 0 of the history doubles as the negedge flop and as q.
  always_comb begin
    w_hist_nxt[0] = bus.a;
    for (int unsigned k = 1; k < DEPTH; k++)
      w_hist_nxt[k] = r_hist[k-1];

    w_all_eq = 1'b1;
    for (int unsigned k = 1; k < DEPTH; k++)
      if (w_hist_nxt[k] != w_hist_nxt[0])
        w_all_eq = 1'b0;

    w_fill_nxt = (r_fill == FILL_W'(DEPTH)) ? r_fill : r_fill + 1'b1;

    w_cnt_nxt = r_cnt;
    if ((bus.a != r_hist[0]) && (r_cnt != '1))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < DEPTH; k++)
        r_hist[k] <= '0;
      r_fill   <= '0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++)
        r_hist[k] <= w_hist_nxt[k];
      r_fill   <= w_fill_nxt;
      r_stable <= (w_fill_nxt == FILL_W'(DEPTH)) && w_all_eq;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_p = r_lhi;
    case (w_sel)
      SEL_LHI:  w_p = r_lhi;
      SEL_LLO:  w_p = r_llo;
      SEL_FPOS: w_p = r_fpos;
      SEL_FNEG: w_p = r_hist[0];
      default:  w_p = r_lhi;
    endcase
  end

  assign bus.p        = w_p;
  assign bus.q        = r_hist[0];
  assign bus.stable   = r_stable;
  assign bus.edge_cnt = r_cnt;

  for (genvar g = 0; g < DEPTH; g++) begin : g_hist
    assign bus.hist[g*WIDTH +: WIDTH] = r_hist[g];
  end

endmodule

// File: tb/tb_phase_sampler_bank.sv
// Self-checking bench for phase_sampler_bank: directed scenarios plus random
// stimulus, compared against a queue-based behavioural model.
module tb_phase_sampler_bank;

  localparam int W = 8;
  localparam int D = 4;
  localparam int C = 2;
  localparam int CMAX = (1 << C) - 1;

  logic clock;
  logic resetn;

  phase_sampler_bank_if #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) bus ();

  phase_sampler_bank #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Behavioural model
  logic [W-1:0] m_lhi, m_llo, m_fpos, m_q;
  logic [W-1:0] m_hist[$];
  int           m_fill;
  int           m_changes;
  logic         m_stable;

  int n_vec  = 0;
  int n_fail = 0;
  event chk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Single compare process: every settled step checks all outputs.
  initial begin
    logic [W-1:0]   exp_p;
    logic [W*D-1:0] exp_hist;
    int             exp_cnt;
    forever begin
      @(chk);
      case (bus.mode)
        2'b00:   exp_p = m_lhi;
        2'b01:   exp_p = m_llo;
        2'b10:   exp_p = m_fpos;
        default: exp_p = m_q;
      endcase
      for (int k = 0; k < D; k++)
        exp_hist[k*W +: W] = m_hist[k];
      exp_cnt = (m_changes > CMAX) ? CMAX : m_changes;
      cmp("p", 64'(bus.p), 64'(exp_p));
      cmp("q", 64'(bus.q), 64'(m_q));
      cmp("hist", 64'(bus.hist), 64'(exp_hist));
      cmp("stable", 64'(bus.stable), 64'(m_stable));
      cmp("edge_cnt", 64'(bus.edge_cnt), 64'(exp_cnt));
    end
  end

  task automatic settle();
    #2;
    ->chk;
    #1;
  endtask

  task automatic model_clear();
    m_lhi = '0; m_llo = '0; m_fpos = '0; m_q = '0;
    m_hist = {};
    for (int k = 0; k < D; k++) m_hist.push_back('0);
    m_fill = 0; m_changes = 0; m_stable = 1'b0;
  endtask

  task automatic upd_lat();
    if (resetn) begin
      if (clock) m_lhi = bus.a;
      else       m_llo = bus.a;
    end
  endtask

  task automatic set_a(input logic [W-1:0] v);
    bus.a = v;
    upd_lat();
    settle();
  endtask

  task automatic set_mode(input logic [1:0] m);
    bus.mode = m;
    settle();
  endtask

  task automatic rise();
    if (resetn) m_fpos = bus.a;
    clock = 1'b1;
    upd_lat();
    settle();
  endtask

  task automatic fall();
    if (resetn) begin
      if (bus.a != m_q) m_changes++;
      m_q = bus.a;
      m_hist.push_front(bus.a);
      void'(m_hist.pop_back());
      if (m_fill < D) m_fill++;
      m_stable = (m_fill == D);
      foreach (m_hist[k]) if (m_hist[k] != m_hist[0]) m_stable = 1'b0;
    end
    clock = 1'b0;
    upd_lat();
    settle();
  endtask

  task automatic set_rst(input logic v);
    resetn = v;
    if (!v) model_clear();
    upd_lat();
    settle();
  endtask

  int exp5[5] = '{1, 2, 3, 3, 3};

  initial begin
    // 1: reset with clock high, then release with clock still high
    clock = 1'b1; resetn = 1'b0; bus.mode = 2'b00; bus.a = 8'hFF;
    model_clear();
    settle();
    cmp("rst_p", 64'(bus.p), 64'h0);
    cmp("rst_q", 64'(bus.q), 64'h0);
    cmp("rst_hist", 64'(bus.hist), 64'h0);
    cmp("rst_stable", 64'(bus.stable), 64'h0);
    cmp("rst_cnt", 64'(bus.edge_cnt), 64'h0);
    set_rst(1'b1);
    cmp("rel_p", 64'(bus.p), 64'hFF);

    // 2: high latch tracks, then holds in the low phase
    set_a(8'h12); cmp("lhi_12", 64'(bus.p), 64'h12);
    set_a(8'h34); cmp("lhi_34", 64'(bus.p), 64'h34);
    fall();       cmp("q_34", 64'(bus.q), 64'h34);
    set_a(8'h56); cmp("lhi_hold", 64'(bus.p), 64'h34);

    // 3: each element holds its own phase of the data
    set_a(8'h5A); rise(); set_a(8'hA5); fall(); set_a(8'h3C);
    set_mode(2'b10); cmp("fpos_5A", 64'(bus.p), 64'h5A);
    set_mode(2'b11); cmp("fneg_A5", 64'(bus.p), 64'hA5);
    set_mode(2'b01); cmp("llo_3C", 64'(bus.p), 64'h3C);

    // 4: stable rises at the DEPTH-th negedge of a held value
    set_rst(1'b0); set_a(8'hA5); set_rst(1'b1);
    for (int i = 1; i <= D; i++) begin
      rise(); fall();
      cmp($sformatf("stable_n%0d", i), 64'(bus.stable), 64'(i == D));
    end
    set_a(8'hA4); rise(); fall();
    cmp("stable_drop", 64'(bus.stable), 64'h0);

    // 5: change counter saturates
    set_rst(1'b0); set_rst(1'b1);
    for (int i = 0; i < 5; i++) begin
      set_a((i % 2 == 0) ? 8'h01 : 8'h02);
      rise(); fall();
      cmp($sformatf("cnt_%0d", i), 64'(bus.edge_cnt), 64'(exp5[i]));
    end

    // 6: mode switch with no clock edge, then mid-run reset
    set_mode(2'b00); set_a(8'h22); rise(); set_a(8'h11); fall();
    cmp("sw_lhi", 64'(bus.p), 64'h11);
    set_mode(2'b10);
    cmp("sw_fpos", 64'(bus.p), 64'h22);
    set_rst(1'b0);
    cmp("mid_p", 64'(bus.p), 64'h0);
    cmp("mid_q", 64'(bus.q), 64'h0);
    cmp("mid_hist", 64'(bus.hist), 64'h0);
    cmp("mid_cnt", 64'(bus.edge_cnt), 64'h0);
    set_rst(1'b1);
    for (int i = 1; i <= D; i++) begin
      rise(); fall();
      cmp($sformatf("mid_stable_n%0d", i), 64'(bus.stable), 64'(i == D));
    end

    // Random phase
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15)
        set_a(($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 3)));
      else if (r < 28)
        set_mode(2'($urandom));
      else if (r < 96) begin
        if (clock) fall();
        else       rise();
      end else begin
        set_rst(1'b0);
        if ($urandom_range(0, 1) == 1) set_a(8'($urandom));
        set_rst(1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
